// File: rtl/multicycle_controller_hs.sv
// Main FSM controller for the multicycle RV32I core with memory handshake,
// wait timeout, illegal-opcode trap, ECALL halt and a retired-instruction counter.
module multicycle_controller_hs #(
    parameter int WAIT_LIMIT   = 16,
    parameter int CNT_W        = 32,
    parameter bit TRAP_ILLEGAL = 1'b1,
    parameter bit HAS_AUIPC    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic             zero,
    input  logic             neg,
    input  logic             memReady,
    output logic             memReq,
    output logic             PCUpdate,
    output logic             adrSrc,
    output logic             memWrite,
    output logic             branch,
    output logic             IRWrite,
    output logic             regWrite,
    output logic [1:0]       resultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [2:0]       immSrc,
    output logic             halted,
    output logic             error,
    output logic [1:0]       errCode,
    output logic [CNT_W-1:0] instret
);

    localparam int WCNT_W = $clog2(WAIT_LIMIT + 2);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_ECALL = 7'b1110011;

    typedef enum logic [4:0] {
        S_FETCH, S_DECODE, S_EX_R, S_EX_I, S_EX_LD, S_EX_ST, S_EX_BR,
        S_EX_JAL, S_JAL_LINK, S_PC_JUMP, S_EX_JALR, S_JALR_PC, S_EX_AUIPC,
        S_LUI, S_MEM_RD, S_MEM_WR, S_WB_LD, S_WB_ALU, S_HALT, S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [WCNT_W-1:0]  wait_q, wait_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic               mem_state;
    logic               illegal;
    logic               timeout;

    // Branch flags are consumed by the datapath, not by this FSM.
    logic unused_flags;
    assign unused_flags = zero | neg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_FETCH;
            wait_q     <= '0;
            err_code_q <= 2'b00;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            err_code_q <= err_code_d;
            instret_q  <= instret_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        mem_state  = 1'b0;
        illegal    = 1'b0;
        timeout    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_state = 1'b1;
                if (memReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_R:     state_d = S_EX_R;
                    OP_I:     state_d = S_EX_I;
                    OP_LD:    state_d = S_EX_LD;
                    OP_ST:    state_d = S_EX_ST;
                    OP_BR:    state_d = S_EX_BR;
                    OP_JAL:   state_d = S_EX_JAL;
                    OP_JALR:  state_d = S_EX_JALR;
                    OP_LUI:   state_d = S_LUI;
                    OP_AUIPC: begin
                        if (HAS_AUIPC) state_d = S_EX_AUIPC;
                        else           illegal = 1'b1;
                    end
                    OP_ECALL: state_d = S_HALT;
                    default:  illegal = 1'b1;
                endcase
            end
            S_EX_R, S_EX_I, S_EX_AUIPC, S_JALR_PC: state_d = S_WB_ALU;
            S_EX_LD:    state_d = S_MEM_RD;
            S_EX_ST:    state_d = S_MEM_WR;
            S_EX_BR:    state_d = S_FETCH;
            S_EX_JAL:   state_d = S_JAL_LINK;
            S_JAL_LINK: state_d = S_PC_JUMP;
            S_PC_JUMP:  state_d = S_FETCH;
            S_EX_JALR:  state_d = S_JALR_PC;
            S_LUI:      state_d = S_FETCH;
            S_MEM_RD: begin
                mem_state = 1'b1;
                if (memReady) state_d = S_WB_LD;
            end
            S_MEM_WR: begin
                mem_state = 1'b1;
                if (memReady) state_d = S_FETCH;
            end
            S_WB_LD, S_WB_ALU: state_d = S_FETCH;
            S_HALT, S_ERR:     state_d = state_q;
            default:           state_d = S_FETCH;
        endcase

        if (illegal) begin
            if (TRAP_ILLEGAL) begin
                state_d    = S_ERR;
                err_code_d = 2'b01;
            end else begin
                state_d = S_FETCH;
            end
        end

        // A memReady in the last allowed cycle still completes the access.
        timeout = (WAIT_LIMIT != 0) && mem_state && !memReady && (wait_q == WAIT_LAST);
        if (timeout) begin
            state_d    = S_ERR;
            err_code_d = 2'b10;
        end
    end

    always_comb begin
        wait_d = '0;
        if (mem_state && (state_d == state_q)) begin
            wait_d = (wait_q == '1) ? wait_q : wait_q + WCNT_W'(1);
        end
        instret_d = instret_q;
        if ((state_d == S_FETCH) && (state_q != S_FETCH)) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    always_comb begin
        memReq    = 1'b0;
        PCUpdate  = 1'b0;
        adrSrc    = 1'b0;
        memWrite  = 1'b0;
        branch    = 1'b0;
        IRWrite   = 1'b0;
        regWrite  = 1'b0;
        resultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        immSrc    = 3'b000;
        halted    = 1'b0;
        error     = 1'b0;
        case (state_q)
            S_FETCH: begin
                memReq    = 1'b1;
                ALUSrcB   = 2'b10;
                resultSrc = 2'b10;
                IRWrite   = memReady;
                PCUpdate  = memReady;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                immSrc  = 3'b010;
            end
            S_EX_R: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EX_I: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b11;
            end
            S_EX_LD, S_EX_JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_EX_ST: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                immSrc  = 3'b001;
            end
            S_EX_BR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                branch  = 1'b1;
            end
            S_EX_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
            end
            S_JAL_LINK: begin
                regWrite = 1'b1;
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b01;
                immSrc   = 3'b011;
            end
            S_PC_JUMP: PCUpdate = 1'b1;
            S_JALR_PC: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                PCUpdate = 1'b1;
            end
            S_EX_AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                immSrc  = 3'b100;
            end
            S_LUI: begin
                resultSrc = 2'b11;
                immSrc    = 3'b100;
                regWrite  = 1'b1;
            end
            S_MEM_RD: begin
                memReq = 1'b1;
                adrSrc = 1'b1;
            end
            S_MEM_WR: begin
                memReq   = 1'b1;
                adrSrc   = 1'b1;
                memWrite = 1'b1;
            end
            S_WB_LD: begin
                resultSrc = 2'b01;
                regWrite  = 1'b1;
            end
            S_WB_ALU: regWrite = 1'b1;
            S_HALT:   halted = 1'b1;
            S_ERR:    error = 1'b1;
            default: ;
        endcase
    end

    assign errCode = err_code_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_controller_hs.sv
// Bench: three controller instances with different parameters driven by the same
// random opcode/memReady stream, checked every cycle against a micro-step plan model.
module tb_multicycle_controller_hs;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic       zero, neg;
    logic       memReady;

    logic       memReq_w[3], PCUpdate_w[3], adrSrc_w[3], memWrite_w[3], branch_w[3];
    logic       IRWrite_w[3], regWrite_w[3], halted_w[3], error_w[3];
    logic [1:0] resultSrc_w[3], ALUSrcA_w[3], ALUSrcB_w[3], ALUOp_w[3], errCode_w[3];
    logic [2:0] immSrc_w[3];
    logic [3:0]  instret_a;
    logic [31:0] instret_b, instret_c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_controller_hs #(.WAIT_LIMIT(4), .CNT_W(4), .TRAP_ILLEGAL(1'b1), .HAS_AUIPC(1'b1)) dut_a (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .neg(neg), .memReady(memReady),
        .memReq(memReq_w[0]), .PCUpdate(PCUpdate_w[0]), .adrSrc(adrSrc_w[0]), .memWrite(memWrite_w[0]),
        .branch(branch_w[0]), .IRWrite(IRWrite_w[0]), .regWrite(regWrite_w[0]), .resultSrc(resultSrc_w[0]),
        .ALUSrcA(ALUSrcA_w[0]), .ALUSrcB(ALUSrcB_w[0]), .ALUOp(ALUOp_w[0]), .immSrc(immSrc_w[0]),
        .halted(halted_w[0]), .error(error_w[0]), .errCode(errCode_w[0]), .instret(instret_a));

    multicycle_controller_hs #(.WAIT_LIMIT(0), .CNT_W(32), .TRAP_ILLEGAL(1'b0), .HAS_AUIPC(1'b0)) dut_b (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .neg(neg), .memReady(memReady),
        .memReq(memReq_w[1]), .PCUpdate(PCUpdate_w[1]), .adrSrc(adrSrc_w[1]), .memWrite(memWrite_w[1]),
        .branch(branch_w[1]), .IRWrite(IRWrite_w[1]), .regWrite(regWrite_w[1]), .resultSrc(resultSrc_w[1]),
        .ALUSrcA(ALUSrcA_w[1]), .ALUSrcB(ALUSrcB_w[1]), .ALUOp(ALUOp_w[1]), .immSrc(immSrc_w[1]),
        .halted(halted_w[1]), .error(error_w[1]), .errCode(errCode_w[1]), .instret(instret_b));

    multicycle_controller_hs dut_c (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .neg(neg), .memReady(memReady),
        .memReq(memReq_w[2]), .PCUpdate(PCUpdate_w[2]), .adrSrc(adrSrc_w[2]), .memWrite(memWrite_w[2]),
        .branch(branch_w[2]), .IRWrite(IRWrite_w[2]), .regWrite(regWrite_w[2]), .resultSrc(resultSrc_w[2]),
        .ALUSrcA(ALUSrcA_w[2]), .ALUSrcB(ALUSrcB_w[2]), .ALUOp(ALUOp_w[2]), .immSrc(immSrc_w[2]),
        .halted(halted_w[2]), .error(error_w[2]), .errCode(errCode_w[2]), .instret(instret_c));

    // Parameters of each instance, as seen by the model.
    int wl_p[3]    = '{4, 0, 16};
    bit trap_p[3]  = '{1'b1, 1'b0, 1'b1};
    bit auipc_p[3] = '{1'b1, 1'b0, 1'b1};
    int cntw_p[3]  = '{4, 32, 32};

    // Micro-step kinds of the instruction table.
    localparam int K_FETCH = 0,  K_DEC = 1,   K_EXR = 2,    K_EXI = 3,    K_EXLD = 4;
    localparam int K_EXST  = 5,  K_EXBR = 6,  K_EXJAL = 7,  K_JLINK = 8,  K_PCJ = 9;
    localparam int K_EXJALR = 10, K_JALRPC = 11, K_AUIPC = 12, K_LUI = 13, K_MRD = 14;
    localparam int K_MWR   = 15, K_WBLD = 16, K_WBALU = 17, K_HALT = 18, K_ERR = 19;

    int          plan[3][4];
    int          plen[3];
    int          pidx[3];
    int          waitc[3];
    logic [1:0]  ecode[3];
    logic [31:0] iret[3];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [21:0] exp_outs(input int k, input logic mr, input logic [1:0] code);
        logic mreq, adr, mw, br, irw, rw, pcu, h, e;
        logic [1:0] rs, a, b, aop, ec;
        logic [2:0] imm;
        {mreq, adr, mw, br, irw, rw, pcu, h, e} = '0;
        {rs, a, b, aop, ec} = '0;
        imm = 3'b000;
        case (k)
            K_FETCH:  begin mreq = 1; b = 2'b10; rs = 2'b10; irw = mr; pcu = mr; end
            K_DEC:    begin a = 2'b01; b = 2'b01; imm = 3'b010; end
            K_EXR:    begin a = 2'b10; aop = 2'b10; end
            K_EXI:    begin a = 2'b10; b = 2'b01; aop = 2'b11; end
            K_EXLD, K_EXJALR: begin a = 2'b10; b = 2'b01; end
            K_EXST:   begin a = 2'b10; b = 2'b01; imm = 3'b001; end
            K_EXBR:   begin a = 2'b10; aop = 2'b01; br = 1; end
            K_EXJAL:  begin a = 2'b01; b = 2'b10; end
            K_JLINK:  begin rw = 1; a = 2'b01; b = 2'b01; imm = 3'b011; end
            K_PCJ:    pcu = 1;
            K_JALRPC: begin a = 2'b01; b = 2'b10; pcu = 1; end
            K_AUIPC:  begin a = 2'b01; b = 2'b01; imm = 3'b100; end
            K_LUI:    begin rs = 2'b11; imm = 3'b100; rw = 1; end
            K_MRD:    begin mreq = 1; adr = 1; end
            K_MWR:    begin mreq = 1; adr = 1; mw = 1; end
            K_WBLD:   begin rs = 2'b01; rw = 1; end
            K_WBALU:  rw = 1;
            K_HALT:   h = 1;
            K_ERR:    begin e = 1; ec = code; end
            default: ;
        endcase
        return {mreq, adr, mw, br, irw, rw, pcu, rs, a, b, aop, imm, h, e, ec};
    endfunction

    function automatic logic [21:0] got_outs(input int i);
        return {memReq_w[i], adrSrc_w[i], memWrite_w[i], branch_w[i], IRWrite_w[i], regWrite_w[i],
                PCUpdate_w[i], resultSrc_w[i], ALUSrcA_w[i], ALUSrcB_w[i], ALUOp_w[i], immSrc_w[i],
                halted_w[i], error_w[i], errCode_w[i]};
    endfunction

    function automatic logic [31:0] got_instret(input int i);
        if (i == 0) return {28'b0, instret_a};
        if (i == 1) return instret_b;
        return instret_c;
    endfunction

    task automatic set_plan(input int i, input int a, input int b, input int c, input int n);
        plan[i][0] = a; plan[i][1] = b; plan[i][2] = c; plan[i][3] = 0;
        plen[i] = n; pidx[i] = 0; waitc[i] = 0;
    endtask

    task automatic retire(input int i);
        logic [31:0] mask;
        mask = (cntw_p[i] >= 32) ? 32'hFFFF_FFFF : ((32'h1 << cntw_p[i]) - 32'h1);
        iret[i] = (iret[i] + 32'h1) & mask;
        set_plan(i, K_FETCH, 0, 0, 1);
    endtask

    task automatic illegal_op(input int i);
        if (trap_p[i]) begin
            set_plan(i, K_ERR, 0, 0, 1);
            ecode[i] = 2'b01;
        end else begin
            retire(i);
        end
    endtask

    task automatic advance(input int i);
        pidx[i]++;
        waitc[i] = 0;
        if (pidx[i] == plen[i]) retire(i);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            set_plan(i, K_FETCH, 0, 0, 1);
            ecode[i] = 2'b00;
            iret[i]  = 32'h0;
        end
    endtask

    task automatic model_step(input int i, input logic [6:0] o, input logic mr);
        int k;
        k = plan[i][pidx[i]];
        case (k)
            K_HALT, K_ERR: ;
            K_FETCH, K_MRD, K_MWR: begin
                if (mr) begin
                    if (k == K_FETCH) set_plan(i, K_DEC, 0, 0, 1);
                    else              advance(i);
                end else if (wl_p[i] != 0 && waitc[i] == wl_p[i] - 1) begin
                    set_plan(i, K_ERR, 0, 0, 1);
                    ecode[i] = 2'b10;
                end else begin
                    waitc[i]++;
                end
            end
            K_DEC: begin
                case (o)
                    7'b0110011: set_plan(i, K_EXR, K_WBALU, 0, 2);
                    7'b0010011: set_plan(i, K_EXI, K_WBALU, 0, 2);
                    7'b0000011: set_plan(i, K_EXLD, K_MRD, K_WBLD, 3);
                    7'b0100011: set_plan(i, K_EXST, K_MWR, 0, 2);
                    7'b1100011: set_plan(i, K_EXBR, 0, 0, 1);
                    7'b1101111: set_plan(i, K_EXJAL, K_JLINK, K_PCJ, 3);
                    7'b1100111: set_plan(i, K_EXJALR, K_JALRPC, K_WBALU, 3);
                    7'b0110111: set_plan(i, K_LUI, 0, 0, 1);
                    7'b0010111: begin
                        if (auipc_p[i]) set_plan(i, K_AUIPC, K_WBALU, 0, 2);
                        else            illegal_op(i);
                    end
                    7'b1110011: set_plan(i, K_HALT, 0, 0, 1);
                    default:    illegal_op(i);
                endcase
            end
            default: advance(i);
        endcase
    endtask

    task automatic compare_all();
        int k;
        for (int i = 0; i < 3; i++) begin
            k = plan[i][pidx[i]];
            check_eq($sformatf("outs_dut%0d_step%0d", i, k), {10'b0, got_outs(i)},
                     {10'b0, exp_outs(k, memReady, ecode[i])});
            check_eq($sformatf("instret_dut%0d", i), got_instret(i), iret[i]);
        end
    endtask

    // Entered and left at a falling edge.
    task automatic run_cycle(input logic [6:0] o, input logic mr);
        op = o;
        memReady = mr;
        #1;
        compare_all();
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i, o, mr);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic mr);
        rst = 1'b1;
        memReady = mr;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        @(negedge clk);
        #1;
        compare_all();
        rst = 1'b0;
    endtask

    logic [6:0] op_tbl[10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                               7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011};

    function automatic logic [6:0] rand_op();
        int r;
        r = $urandom_range(0, 99);
        if (r < 3)  return 7'b1110011;
        if (r < 6)  return 7'b1111111;
        if (r < 9)  return 7'($urandom);
        return op_tbl[$urandom_range(0, 8)];
    endfunction

    initial begin
        int low_left;
        int r;
        logic mr;
        rst = 1'b1;
        op = 7'h0;
        memReady = 1'b0;
        zero = 1'b0;
        neg = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset decode with memReady low and high.
        do_reset(1'b0);
        do_reset(1'b1);

        // memReady stuck low in FETCH: the 4-cycle limit instance traps.
        do_reset(1'b0);
        for (int c = 0; c < 6; c++) run_cycle(7'b0110011, 1'b0);
        check_eq("timeout_error", {31'b0, error_w[0]}, 32'h1);
        check_eq("timeout_code", {30'b0, errCode_w[0]}, 32'h2);

        // memReady arriving in the last allowed cycle wins.
        do_reset(1'b0);
        for (int c = 0; c < 3; c++) run_cycle(7'b0110011, 1'b0);
        run_cycle(7'b0110011, 1'b1);
        check_eq("late_ready_no_err", {31'b0, error_w[0]}, 32'h0);

        // Single ADD with memReady high.
        do_reset(1'b1);
        for (int c = 0; c < 4; c++) run_cycle(7'b0110011, 1'b1);
        check_eq("add_instret", instret_b, 32'h1);

        // LW with three low cycles in MEM_RD: 8 clocks total.
        do_reset(1'b1);
        run_cycle(7'b0000011, 1'b1);
        run_cycle(7'b0000011, 1'b1);
        run_cycle(7'b0000011, 1'b1);
        for (int c = 0; c < 3; c++) run_cycle(7'b0000011, 1'b0);
        run_cycle(7'b0000011, 1'b1);
        run_cycle(7'b0000011, 1'b1);
        check_eq("lw_instret", instret_c, 32'h1);

        // Sixteen LUIs wrap the 4-bit counter.
        do_reset(1'b1);
        for (int c = 0; c < 48; c++) run_cycle(7'b0110111, 1'b1);
        check_eq("lui_wrap_a", {28'b0, instret_a}, 32'h0);
        check_eq("lui_count_b", instret_b, 32'd16);

        // JAL then ECALL, halt held.
        do_reset(1'b1);
        for (int c = 0; c < 5; c++) run_cycle(7'b1101111, 1'b1);
        for (int c = 0; c < 100; c++) run_cycle(7'b1110011, 1'b1);
        check_eq("halt_held", {31'b0, halted_w[2]}, 32'h1);
        check_eq("halt_instret", instret_c, 32'h1);

        // AUIPC: illegal in the no-AUIPC instance (returns to FETCH there).
        do_reset(1'b1);
        for (int c = 0; c < 4; c++) run_cycle(7'b0010111, 1'b1);
        check_eq("auipc_b_instret", instret_b, 32'h2);

        // Randomised segments, each starting from reset.
        low_left = 0;
        for (int s = 0; s < 30; s++) begin
            do_reset(1'($urandom));
            for (int c = 0; c < 120; c++) begin
                if (low_left > 0) begin
                    mr = 1'b0;
                    low_left--;
                end else begin
                    r = $urandom_range(0, 99);
                    if (r < 3) low_left = $urandom_range(3, 18);
                    mr = (r >= 25);
                end
                run_cycle(rand_op(), mr);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller_hs.md
# multicycle_controller_hs

Parametrised main controller for the multicycle RV32I core. It replaces the fixed-latency controller with one that handshakes with variable-latency memory and adds AUIPC and ECALL halt. It traps illegal opcodes and memory timeouts, and keeps a retired-instruction counter. It sits between the instruction register's opcode field and the existing datapath, and its control-signal encodings are unchanged.

## Interface
- WAIT_LIMIT, 16: maximum consecutive cycles with memReady low in one memory state; 0 disables the timeout.
- CNT_W, 32: width of instret.
- TRAP_ILLEGAL, 1: 1 sends an unknown opcode to ERR; 0 returns it to FETCH.
- HAS_AUIPC, 1: 0 treats 7'b0010111 as illegal.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  7  opcode, IR[6:0].
- zero, neg  in  1  ALU flags, forwarded to the datapath branch logic.
- memReady  in  1  memory done this cycle.
- memReq  out  1  memory access request.
- PCUpdate, adrSrc, memWrite, branch, IRWrite, regWrite  out  1  datapath strobes.
- resultSrc, ALUSrcA, ALUSrcB, ALUOp  out  2  datapath selects.
- immSrc  out  3  immediate format (000 I, 001 S, 010 B, 011 J, 100 U).
- halted  out  1  ECALL reached.
- error  out  1  in ERR state.
- errCode  out  2  01 illegal opcode, 10 memory timeout, 00 otherwise.
- instret  out  CNT_W  retired instructions, wraps modulo 2^CNT_W.

## Operation
- Outputs are a decode of the present state. Any signal not listed for a state is 0. Only IRWrite and PCUpdate in FETCH also depend on memReady.
- Select encodings:
  - ALUSrcA: 00 PC, 01 oldPC, 10 rs1.
  - ALUSrcB: 00 rs2, 01 imm, 10 const 4.
  - resultSrc: 00 ALUOut, 01 memData, 10 ALUResult, 11 imm.
  - ALUOp: 00 add, 01 branch, 10 R funct, 11 I funct.
- FETCH: memReq=1, adrSrc=0, A=00, B=10, ALUOp=00, resultSrc=10, IRWrite=PCUpdate=memReady. Stays in FETCH while memReady=0; goes to DECODE when memReady=1.
- DECODE: A=01, B=01, immSrc=010. Next state by op:
  - 0110011 → EX_R
  - 0010011 → EX_I
  - 0000011 → EX_LD
  - 0100011 → EX_ST
  - 1100011 → EX_BR
  - 1101111 → EX_JAL
  - 1100111 → EX_JALR
  - 0110111 → LUI
  - 0010111 → EX_AUIPC
  - 1110011 → HALT
  - anything else → ERR (code 01) or FETCH, per TRAP_ILLEGAL.
- EX_R: A=10, B=00, ALUOp=10 → WB_ALU.
- EX_I: A=10, B=01, immSrc=000, ALUOp=11 → WB_ALU.
- EX_LD: A=10, B=01, immSrc=000 → MEM_RD.
- EX_ST: same as EX_LD but immSrc=001 → MEM_WR.
- EX_BR: A=10, B=00, ALUOp=01, branch=1 → FETCH.
- EX_JAL: A=01, B=10 → JAL_LINK.
- JAL_LINK: regWrite=1, A=01, B=01, immSrc=011 → PC_JUMP.
- PC_JUMP: PCUpdate=1 → FETCH.
- EX_JALR: A=10, B=01, immSrc=000 → JALR_PC.
- JALR_PC: A=01, B=10, PCUpdate=1 → WB_ALU.
- EX_AUIPC: A=01, B=01, immSrc=100 → WB_ALU.
- LUI: resultSrc=11, immSrc=100, regWrite=1 → FETCH.
- MEM_RD: memReq=1, adrSrc=1. Holds until memReady=1, then → WB_LD.
- MEM_WR: memReq=1, adrSrc=1, memWrite=1. Holds until memReady=1, then → FETCH. Memory commits in the memReady cycle.
- WB_LD: resultSrc=01, regWrite=1 → FETCH.
- WB_ALU: regWrite=1 → FETCH.
- HALT: halted=1. Self-loop until rst.
- ERR: error=1, errCode held. Self-loop until rst. No strobes asserted.
- instret increments by 1 on every transition from a non-FETCH state into FETCH. HALT and ERR never increment it.

## Timing
- Reset:
  - state=FETCH, instret=0, wait counter=0, errCode=00.
  - All outputs equal the FETCH decode with memReady applied, so memReq=1 immediately after reset.
  - rst mid-access abandons the access. The memory side must tolerate memReq dropping.
- Latency with memReady tied high, counted in clocks from FETCH to the next FETCH:
  - R / I / AUIPC: 4.
  - LD: 5.
  - ST: 4.
  - BR: 3.
  - JAL / JALR: 5.
  - LUI: 3.
  - Each memReady-low cycle adds one clock.
- Wait counter:
  - Cleared on entry to FETCH, MEM_RD or MEM_WR. Increments each cycle that state holds with memReady=0.
  - With WAIT_LIMIT=N≠0: if the counter equals N−1 and memReady=0, the next state is ERR with code 10. A memReady=1 in that same cycle wins, and the access completes normally.
  - The counter saturates and does not wrap when WAIT_LIMIT=0.
- ERR and HALT outputs are valid the cycle after the deciding edge.

## Test plan
- Reset, then ADD with memReady high → FETCH, DECODE, EX_R, WB_ALU, FETCH; regWrite high exactly 1 cycle; instret=1.
- LW with memReady low for 3 cycles in MEM_RD → memReq and adrSrc held 4 cycles, WB_LD resultSrc=01, total 8 clocks, instret=1.
- WAIT_LIMIT=4, memReady stuck low in FETCH → ERR after 4 cycles, error=1, errCode=10, IRWrite never asserted; memReady arriving in the 4th cycle instead → DECODE.
- Opcode 7'b1111111 → ERR with errCode=01 (TRAP_ILLEGAL=1); with TRAP_ILLEGAL=0 → FETCH after DECODE, instret+1.
- JAL then ECALL → JAL_LINK regWrite=1, PC_JUMP PCUpdate=1, then HALT with halted=1 held 100 cycles, instret frozen at 1; rst clears to FETCH.
- CNT_W=4: 16 LUIs → instret wraps to 0; AUIPC with HAS_AUIPC=0 → ERR code 01.
